rom_dl_sched: RTL

ROM_DL_SCHED -- requirements
Module: rom_dl_sched

---
 rtl/rom_dl_pkg.sv | 19 +
 rtl/rom_dl_wordbuf.sv | 120 ++++++++++++
 rtl/rom_dl_sched.sv | 120 ++++++++++++
 3 files changed

// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the ROM download scheduler.
package rom_dl_pkg;

  // Download scheduler states.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    HOLD,
    RUN
  } state_t;

  // Filler byte for a word half that was never downloaded.
  localparam logic [7:0] PAD_BYTE = 8'hFF;

  // Core-reset hold length after the download completes.
  localparam int HOLD_CYC_DEFAULT = 1024;

endpackage

// File: rtl/rom_dl_wordbuf.sv
// Byte-to-word packer for the ROM download: low-byte latch, one-entry word
// buffer presented to SDRAM as a req/ack write, and the sticky overflow flag.
// With ROM_DL_CHECKSUM_EN defined it also keeps a 16-bit running byte sum.
module rom_dl_wordbuf import rom_dl_pkg::*; (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic        flush,
  input  logic [24:0] addr,
  input  logic [7:0]  din,
  input  logic        sdr_ack,
  output logic        sdr_req,
  output logic [23:0] sdr_addr,
  output logic [15:0] sdr_data,
  output logic        overflow,
  output logic        half_full
`ifdef ROM_DL_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  logic [7:0]  lo_byte;
  logic [23:0] lo_addr;
  logic        lo_en;
  logic        hi_en;
  logic        can_take;
  logic        flush_emit;
  logic        word_done;
  logic [23:0] word_addr;
  logic [15:0] word_data;

  // Decode byte strobes and build the word that completes this cycle, if any.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    lo_en      = byte_en && !addr[0];
    hi_en      = byte_en && addr[0];
    // The buffer is free when empty or being drained by this cycle's ack.
    can_take   = !sdr_req || sdr_ack;
    // A leftover low byte is only pushed out when it cannot be dropped.
    flush_emit = flush && half_full && can_take;
    word_done  = hi_en || flush_emit;
    word_addr  = lo_addr;
    word_data  = {PAD_BYTE, lo_byte};
    if (hi_en) begin
      word_addr = addr[24:1];
      word_data = {din, half_full ? lo_byte : PAD_BYTE};
    end
  end

  // Low-byte latch: filled by an even byte, emptied when its word forms.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lo_byte   <= '0;
      lo_addr   <= '0;
      half_full <= 1'b0;
    end else if (clear) begin
      half_full <= 1'b0;
    end else if (lo_en) begin
      lo_byte   <= din;
      lo_addr   <= addr[24:1];
      half_full <= 1'b1;
    end else if (word_done) begin
      half_full <= 1'b0;
    end
  end

  // Word buffer and request handshake; a word that finds the buffer busy is
  // dropped and flagged.
  // NOTE: the data/address registers are reset as well so the SDRAM port shows
  // defined zeros after reset rather than stale contents.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sdr_req  <= 1'b0;
      sdr_addr <= '0;
      sdr_data <= '0;
      overflow <= 1'b0;
    end else if (word_done && can_take) begin
      sdr_req  <= 1'b1;
      sdr_addr <= word_addr;
      sdr_data <= word_data;
    end else if (word_done) begin
      overflow <= 1'b1;
    end else if (sdr_ack) begin
      sdr_req  <= 1'b0;
    end
  end

`ifdef ROM_DL_CHECKSUM_EN
  logic [15:0] sum_add;

  // Bytes contributed this cycle, counting pad bytes that end up in a word.
  always_comb begin
    sum_add = '0;
    if (lo_en) begin
      sum_add = {8'h00, din};
    end else if (hi_en) begin
      sum_add = {8'h00, din} + (half_full ? 16'h0000 : {8'h00, PAD_BYTE});
    end else if (flush_emit) begin
      sum_add = {8'h00, PAD_BYTE};
    end
  end

  // Running sum; idle outside LOAD/FLUSH, so it holds its value in RUN.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if (clear) begin
      checksum <= '0;
    end else begin
      checksum <= checksum + sum_add;
    end
  end
`endif

endmodule

// File: rtl/rom_dl_sched.sv
// ROM download scheduler: packs ioctl bytes into SDRAM word writes, then holds
// the core in reset for HOLD_CYC cycles before releasing it.
// Optional feature macro: ROM_DL_CHECKSUM_EN adds a 16-bit checksum output.
module rom_dl_sched import rom_dl_pkg::*; #(
  parameter logic [7:0] ROM_INDEX = 8'd0,
  parameter int         HOLD_CYC  = HOLD_CYC_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        reset_req,
  output logic        sdr_req,
  input  logic        sdr_ack,
  output logic [23:0] sdr_addr,
  output logic [15:0] sdr_data,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        overflow
`ifdef ROM_DL_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam int CNT_W = $clog2(HOLD_CYC + 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] hold_cnt;
  logic             idx_match;
  logic             dl_start;
  logic             load_entry;
  logic             byte_en;
  logic             half_full;

  assign idx_match  = ioctl_index == ROM_INDEX;
  assign dl_start   = ioctl_downl && idx_match;
  assign byte_en    = (state == LOAD) && ioctl_wr && idx_match;
  assign load_entry = (state != LOAD) && (state_next == LOAD);

  rom_dl_wordbuf u_wordbuf (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .clear     (load_entry),
    .byte_en   (byte_en),
    .flush     (state == FLUSH),
    .addr      (ioctl_addr),
    .din       (ioctl_dout),
    .sdr_ack   (sdr_ack),
    .sdr_req   (sdr_req),
    .sdr_addr  (sdr_addr),
    .sdr_data  (sdr_data),
    .overflow  (overflow),
    .half_full (half_full)
`ifdef ROM_DL_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  // Next-state logic; a new ROM download preempts every state but LOAD.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, RUN: begin
        if (dl_start) state_next = LOAD;
      end
      LOAD: begin
        if (!ioctl_downl) state_next = FLUSH;
      end
      FLUSH: begin
        if (dl_start) begin
          state_next = LOAD;
        end else if (!half_full && (!sdr_req || sdr_ack)) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (dl_start) begin
          state_next = LOAD;
        end else if (hold_cnt == CNT_W'(HOLD_CYC - 1)) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and hold counter (restarts on every HOLD entry).
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= (state == HOLD && state_next == HOLD) ? hold_cnt + 1'b1 : '0;
    end
  end

  // Core reset and load status; keyed on the next state so core_reset is
  // already low in the first RUN cycle and tracks reset_req one cycle late.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      core_reset <= 1'b1;
      rom_loaded <= 1'b0;
    end else begin
      core_reset <= (state_next != RUN) || reset_req;
      if (load_entry) begin
        rom_loaded <= 1'b0;
      end else if (state == HOLD && state_next == RUN) begin
        rom_loaded <= 1'b1;
      end
    end
  end

endmodule
